// File: rtl/writeback_regfile.sv
// Write-back stage with the 32-entry architectural register file, a pending-write
// scoreboard that drives decode's stall, a sticky halt flag and a retired counter.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_v_i,
  input  logic              wb_i,
  input  logic [RD_W-1:0]   wb_r_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              hlt_i,
  input  logic [RD_W-1:0]   rs0_i,
  input  logic [RD_W-1:0]   rs1_i,
  input  logic              rs0_en_i,
  input  logic              rs1_en_i,
  output logic [DATA_W-1:0] rd_data0_o,
  output logic [DATA_W-1:0] rd_data1_o,
  input  logic              issue_i,
  input  logic              issue_wb_i,
  input  logic [RD_W-1:0]   issue_rd_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam int NREG = 1 << RD_W;
  localparam logic [NREG-1:0]  BIT0     = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREG-1:0]  NO_BITS  = {NREG{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D  = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [NREG-1:0]   clr_s;
  logic [NREG-1:0]   set_s;
  logic              hazard_s;
  logic              halted_r;
  logic [CNT_W-1:0]  retired_r;

  // A register is still pending unless its write-back is landing this very cycle.
  function automatic logic eff_busy(input logic [NREG-1:0] busy,
                                    input logic [RD_W-1:0] idx,
                                    input logic            wb,
                                    input logic [RD_W-1:0] wb_r);
    return busy[idx] & ~(wb & (wb_r == idx));
  endfunction

  // Read ports with same-cycle write bypass.
  always_comb begin
    rd_data0_o = regs_r[rs0_i];
    rd_data1_o = regs_r[rs1_i];
    if (wb_i && (wb_r_i == rs0_i)) begin
      rd_data0_o = wb_data_i;
    end else begin
      rd_data0_o = regs_r[rs0_i];
    end
    if (wb_i && (wb_r_i == rs1_i)) begin
      rd_data1_o = wb_data_i;
    end else begin
      rd_data1_o = regs_r[rs1_i];
    end
  end

  // Hazard detection and scoreboard next state; a set beats a clear of the same bit.
  always_comb begin
    hazard_s = issue_i & ((rs0_en_i   & eff_busy(busy_r, rs0_i, wb_i, wb_r_i)) |
                          (rs1_en_i   & eff_busy(busy_r, rs1_i, wb_i, wb_r_i)) |
                          (issue_wb_i & eff_busy(busy_r, issue_rd_i, wb_i, wb_r_i)));
    clr_s = wb_i ? (BIT0 << wb_r_i) : NO_BITS;
    set_s = (issue_i & issue_wb_i & ~hazard_s & ~flush_i) ? (BIT0 << issue_rd_i) : NO_BITS;
    if (flush_i) begin
      busy_nxt_s = NO_BITS;
    end else begin
      busy_nxt_s = (busy_r & ~clr_s) | set_s;
    end
  end

  assign hazard_o  = hazard_s;
  assign halted_o  = halted_r;
  assign retired_o = retired_r;

  // Register file storage; index 0 is an ordinary register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= ZERO_D;
      end
    end else if (wb_i) begin
      regs_r[wb_r_i] <= wb_data_i;
    end else begin
      regs_r[wb_r_i] <= regs_r[wb_r_i];
    end
  end

  // Scoreboard, sticky halt and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r    <= NO_BITS;
      halted_r  <= 1'b0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      busy_r    <= busy_nxt_s;
      halted_r  <= halted_r | hlt_i;
      retired_r <= wb_v_i ? (retired_r + CNT_ONE) : retired_r;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor compares.
module tb_writeback_regfile;

  typedef struct {
    logic        wb_v, wb, hlt, issue, issue_wb, flush, rs0_en, rs1_en;
    logic [4:0]  wb_r, rs0, rs1, issue_rd;
    logic [31:0] data;
  } stim_t;

  typedef struct {
    logic [31:0] rd0, rd1, retired;
    logic        hazard, halted;
    logic [3:0]  retired_small;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_v_i = 1'b0, wb_i = 1'b0, hlt_i = 1'b0;
  logic [4:0]  wb_r_i = 5'd0, rs0_i = 5'd0, rs1_i = 5'd0, issue_rd_i = 5'd0;
  logic [31:0] wb_data_i = 32'd0;
  logic        rs0_en_i = 1'b0, rs1_en_i = 1'b0;
  logic        issue_i = 1'b0, issue_wb_i = 1'b0, flush_i = 1'b0;
  logic [31:0] rd_data0_o, rd_data1_o, retired_o;
  logic        hazard_o, halted_o;
  logic [31:0] s_rd0, s_rd1;
  logic        s_haz, s_halted;
  logic [3:0]  s_retired;

  writeback_regfile dut (
    .clk(clk), .reset(reset), .wb_v_i(wb_v_i), .wb_i(wb_i), .wb_r_i(wb_r_i),
    .wb_data_i(wb_data_i), .hlt_i(hlt_i), .rs0_i(rs0_i), .rs1_i(rs1_i),
    .rs0_en_i(rs0_en_i), .rs1_en_i(rs1_en_i), .rd_data0_o(rd_data0_o),
    .rd_data1_o(rd_data1_o), .issue_i(issue_i), .issue_wb_i(issue_wb_i),
    .issue_rd_i(issue_rd_i), .flush_i(flush_i), .hazard_o(hazard_o),
    .halted_o(halted_o), .retired_o(retired_o)
  );

  // Narrow counter copy so wrap-around is reached quickly.
  writeback_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .wb_v_i(wb_v_i), .wb_i(wb_i), .wb_r_i(wb_r_i),
    .wb_data_i(wb_data_i), .hlt_i(hlt_i), .rs0_i(rs0_i), .rs1_i(rs1_i),
    .rs0_en_i(rs0_en_i), .rs1_en_i(rs1_en_i), .rd_data0_o(s_rd0),
    .rd_data1_o(s_rd1), .issue_i(issue_i), .issue_wb_i(issue_wb_i),
    .issue_rd_i(issue_rd_i), .flush_i(flush_i), .hazard_o(s_haz),
    .halted_o(s_halted), .retired_o(s_retired)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_halted;
  longint      m_retired;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_halted  = 1'b0;
    m_retired = 0;
  endtask

  function automatic bit pending(input int r, input stim_t s);
    return m_busy[r] && !(s.wb && s.wb_r == r);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   haz;
    wb_v_i = s.wb_v; wb_i = s.wb; wb_r_i = s.wb_r; wb_data_i = s.data;
    hlt_i = s.hlt; rs0_i = s.rs0; rs1_i = s.rs1;
    rs0_en_i = s.rs0_en; rs1_en_i = s.rs1_en;
    issue_i = s.issue; issue_wb_i = s.issue_wb; issue_rd_i = s.issue_rd;
    flush_i = s.flush;
    haz = s.issue && ((s.rs0_en && pending(s.rs0, s)) ||
                      (s.rs1_en && pending(s.rs1, s)) ||
                      (s.issue_wb && pending(s.issue_rd, s)));
    e.rd0 = (s.wb && s.wb_r == s.rs0) ? s.data : m_regs[s.rs0];
    e.rd1 = (s.wb && s.wb_r == s.rs1) ? s.data : m_regs[s.rs1];
    e.hazard = haz;
    e.halted = m_halted;
    e.retired = 32'(m_retired % 64'd4294967296);
    e.retired_small = 4'(m_retired % 16);
    exp_q.push_back(e);
    @(posedge clk);
    if (s.wb) m_regs[s.wb_r] = s.data;
    if (s.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (s.wb) m_busy[s.wb_r] = 1'b0;
      if (s.issue && s.issue_wb && !haz) m_busy[s.issue_rd] = 1'b1;
    end
    if (s.hlt) m_halted = 1'b1;
    if (s.wb_v) m_retired = m_retired + 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT outputs are compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data0_o !== e.rd0) begin
          n_bad++; $display("FAIL rd_data0 got %h want %h at %0t", rd_data0_o, e.rd0, $time);
        end
        if (rd_data1_o !== e.rd1) begin
          n_bad++; $display("FAIL rd_data1 got %h want %h at %0t", rd_data1_o, e.rd1, $time);
        end
        if (hazard_o !== e.hazard) begin
          n_bad++; $display("FAIL hazard got %b want %b at %0t", hazard_o, e.hazard, $time);
        end
        if (halted_o !== e.halted) begin
          n_bad++; $display("FAIL halted got %b want %b at %0t", halted_o, e.halted, $time);
        end
        if (retired_o !== e.retired) begin
          n_bad++; $display("FAIL retired got %0d want %0d at %0t", retired_o, e.retired, $time);
        end
        if (s_retired !== e.retired_small) begin
          n_bad++; $display("FAIL retired_wrap got %0d want %0d at %0t", s_retired, e.retired_small, $time);
        end
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    #12;
    do_reset();

    // reset then read
    s = idle(); s.rs0 = 5'd3; apply(s);
    // write with bypass, then read from storage
    s = idle(); s.wb = 1'b1; s.wb_r = 5'd5; s.data = 32'hDEADBEEF; s.rs1 = 5'd5; apply(s);
    s = idle(); s.rs1 = 5'd5; apply(s);
    // RAW stall on r7
    s = idle(); s.issue = 1'b1; s.issue_wb = 1'b1; s.issue_rd = 5'd7; apply(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.issue = 1'b1; s.rs0 = 5'd7; s.rs0_en = 1'b1; apply(s);
    end
    s = idle(); s.issue = 1'b1; s.rs0 = 5'd7; s.rs0_en = 1'b1;
    s.wb = 1'b1; s.wb_r = 5'd7; s.data = 32'h1234_5678; apply(s);
    // WAW and set-wins on r9
    s = idle(); s.issue = 1'b1; s.issue_wb = 1'b1; s.issue_rd = 5'd9; apply(s);
    apply(s);
    s.wb = 1'b1; s.wb_r = 5'd9; s.data = 32'h0000_0099; apply(s);
    s = idle(); s.issue = 1'b1; s.issue_wb = 1'b1; s.issue_rd = 5'd9; apply(s);
    // flush drops reservations and suppresses a same-cycle issue
    s = idle(); s.issue = 1'b1; s.issue_wb = 1'b1; s.issue_rd = 5'd2; apply(s);
    s.issue_rd = 5'd4; apply(s);
    s.issue_rd = 5'd6; s.flush = 1'b1; apply(s);
    s = idle(); s.issue = 1'b1; s.rs0 = 5'd2; s.rs0_en = 1'b1; s.rs1 = 5'd4; s.rs1_en = 1'b1;
    s.issue_wb = 1'b1; s.issue_rd = 5'd6; apply(s);
    // retire counter and halt
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.wb_v = 1'b1; apply(s);
    end
    s = idle(); s.hlt = 1'b1; apply(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.wb_v = 1'b1; apply(s);
    end

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      s.wb_v     = 1'($urandom_range(0, 1));
      s.wb       = ($urandom_range(0, 2) != 0);
      s.wb_r     = 5'($urandom_range(0, 7));
      s.data     = $urandom;
      s.hlt      = ($urandom_range(0, 199) == 0);
      s.rs0      = 5'($urandom_range(0, 7));
      s.rs1      = 5'($urandom_range(0, 31));
      s.rs0_en   = 1'($urandom_range(0, 1));
      s.rs1_en   = 1'($urandom_range(0, 1));
      s.issue    = ($urandom_range(0, 3) != 0);
      s.issue_wb = 1'($urandom_range(0, 1));
      s.issue_rd = 5'($urandom_range(0, 7));
      s.flush    = ($urandom_range(0, 19) == 0);
      apply(s);
    end

    s = idle(); apply(s);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout got running want finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "timeout");
    end
  end

endmodule
